sine_sweep_ctrl: RTL and testbench
==================================

SINE_SWEEP_CTRL -- requirements
Module: sine_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter D_WIDTH, default 8, giving the phase-increment width; it matches the sine generator's incr width.
REQ-002 The block SHALL have parameter DW_WIDTH, default 16, giving the dwell-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a sweep; sampled only in IDLE.
REQ-006 abort  input  1  terminate the sweep immediately.
REQ-007 mode  input  2  sweep mode: 00 single up, 01 loop up, 10 bounce up/down, 11 treated as 00.
REQ-008 f_start  input  D_WIDTH  first (lowest) increment.
REQ-009 f_stop  input  D_WIDTH  last (highest) increment.
REQ-010 f_step  input  D_WIDTH  increment change per step.
REQ-011 dwell  input  DW_WIDTH  cycles per increment value; 0 treated as 1.
REQ-012 en  output  1  enable to the sine generator's address counter.
REQ-013 incr  output  D_WIDTH  phase increment to the sine generator.
REQ-014 busy  output  1  high in any state except IDLE.
REQ-015 dir  output  1  1 = down leg, 0 otherwise.
REQ-016 done  output  1  one-cycle pulse on normal sweep completion.
REQ-017 err  output  1  one-cycle pulse on rejected start.

Function
REQ-018 The FSM SHALL have states IDLE, UP, DOWN, DONE; all outputs SHALL be registered.
REQ-019 In IDLE, start=1 with f_start<=f_stop, f_step!=0, abort=0 SHALL capture mode, f_start, f_stop, f_step, dwell_eff and enter UP, with incr=f_start, en=1, busy=1 in the next cycle.
REQ-020 In IDLE, start=1 with f_stop<f_start or f_step==0 SHALL keep IDLE and pulse err for one cycle.
REQ-021 Inputs other than abort SHALL be ignored outside IDLE; a start while busy SHALL have no effect.
REQ-022 en SHALL be 1 exactly in UP and DOWN; dir SHALL be 1 exactly in DOWN.
REQ-023 Each incr value SHALL be held for exactly dwell_eff consecutive cycles before it changes or the leg ends.
REQ-024 The UP step SHALL compute incr+f_step at D_WIDTH+1 bits; a result above f_stop, including carry out, SHALL saturate to f_stop.
REQ-025 The DOWN step SHALL compute incr-f_step with borrow detection; a result below f_start, including borrow, SHALL saturate to f_start.
REQ-026 The end of a dwell at incr==f_stop in UP SHALL end the leg, with the next state set by mode.
REQ-027 Single mode: the leg end SHALL go to DONE.
REQ-028 Loop mode: the leg end SHALL set incr=f_start and stay in UP.
REQ-029 Bounce mode: the leg end SHALL go to DOWN with the first down step applied.
REQ-030 The end of a dwell at incr==f_start in DOWN SHALL go to UP with the first up step applied.
REQ-031 If f_start==f_stop, every leg SHALL be one dwell at that value; in bounce mode dir SHALL toggle each dwell.
REQ-032 DONE SHALL last one cycle with done=1, en=0, busy=1 and incr held, then go to IDLE.
REQ-033 abort=1 in UP, DOWN or DONE SHALL go to IDLE next cycle with en=0, busy=0, dir=0, and SHALL NOT pulse done.
REQ-034 abort and start together in IDLE SHALL be resolved as abort: no sweep and no err.
REQ-035 In IDLE, incr SHALL hold its last value and en SHALL be 0.

Reset
REQ-036 rst=1 SHALL set state IDLE, incr=0, en=0, busy=0, dir=0, done=0, err=0, and clear the dwell counter and captured configuration.
REQ-037 rst SHALL override start and abort in the same cycle.
REQ-038 rst asserted mid-sweep SHALL reach the reset values on the next edge with no done pulse.

Verification
REQ-039 Single sweep: f_start=10, f_stop=20, f_step=4, dwell=3, mode=00 -> incr 10,14,18,20 each held 3 cycles; en high for 12 cycles; then one cycle done=1, en=0; then IDLE.
REQ-040 Bounce: same values, mode=10 -> incr 10,14,18,20,16,12,10,14..., dwell 3 each; dir=1 during 16,12,10.
REQ-041 Loop with overflow: f_start=250, f_stop=255, f_step=4, dwell=0, mode=01 -> incr 250,254,255,250,254... one cycle each; never 2 (no wrap).
REQ-042 Rejected config: f_start=30, f_stop=20, start pulse -> err pulse for 1 cycle, busy stays 0, incr unchanged; f_step=0 -> same.
REQ-043 Abort and reset: abort during the second dwell of the REQ-039 setup -> en=0, busy=0 next cycle, no done; repeat with rst instead -> incr=0.
REQ-044 start held high during a sweep and at the DONE cycle -> no restart until IDLE; a new sweep starts one cycle after IDLE is reached if start is still high.

Source files
------------

// File: rtl/sine_sweep_ctrl.sv
// Frequency-sweep controller: steps the sine generator's phase increment from
// f_start to f_stop in f_step increments, dwelling a fixed number of cycles on
// each value. Supports single, looping and bounce (up/down) sweeps.
module sine_sweep_ctrl #(
  parameter int unsigned D_WIDTH  = 8,
  parameter int unsigned DW_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          mode,
  input  logic [D_WIDTH-1:0]  f_start,
  input  logic [D_WIDTH-1:0]  f_stop,
  input  logic [D_WIDTH-1:0]  f_step,
  input  logic [DW_WIDTH-1:0] dwell,
  output logic                en,
  output logic [D_WIDTH-1:0]  incr,
  output logic                busy,
  output logic                dir,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_DONE} state_t;

  localparam logic [1:0] M_LOOP   = 2'b01;
  localparam logic [1:0] M_BOUNCE = 2'b10;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_mode;
  logic [D_WIDTH-1:0]  r_fstart, r_fstop, r_fstep;
  logic [DW_WIDTH-1:0] r_dwell, r_cnt, w_cnt_nxt, w_dwell_eff;
  logic [D_WIDTH-1:0]  r_incr, w_incr_nxt;
  logic                r_en, r_busy, r_dir, r_done, r_err;
  logic                w_en_nxt, w_busy_nxt, w_dir_nxt, w_done_nxt, w_err_nxt;
  logic                w_cfg_ok, w_accept, w_dwell_end;
  logic [D_WIDTH:0]    w_up_sum, w_dn_diff;
  logic [D_WIDTH-1:0]  w_up_val, w_dn_val;

  assign w_cfg_ok    = (f_start <= f_stop) && (f_step != '0);
  assign w_accept    = (r_state == S_IDLE) && start && !abort && w_cfg_ok;
  assign w_dwell_eff = (dwell == '0) ? DW_WIDTH'(1) : dwell;
  assign w_dwell_end = (r_cnt == r_dwell - DW_WIDTH'(1));

  // Saturating steps: the extra MSB catches carry out / borrow so a wrap can
  // never slip past the configured bounds.
  assign w_up_sum  = {1'b0, r_incr} + {1'b0, r_fstep};
  assign w_dn_diff = {1'b0, r_incr} - {1'b0, r_fstep};
  assign w_up_val  = (w_up_sum > {1'b0, r_fstop}) ? r_fstop : w_up_sum[D_WIDTH-1:0];
  assign w_dn_val  = (w_dn_diff[D_WIDTH] || (w_dn_diff[D_WIDTH-1:0] < r_fstart))
                     ? r_fstart : w_dn_diff[D_WIDTH-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state, next increment and dwell-counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_incr_nxt  = r_incr;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_UP;
          w_incr_nxt  = f_start;
          w_cnt_nxt   = '0;
        end
      end
      S_UP: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_dwell_end) begin
          w_cnt_nxt = '0;
          if (r_incr == r_fstop) begin
            if (r_mode == M_LOOP) begin
              w_incr_nxt = r_fstart;
            end else if (r_mode == M_BOUNCE) begin
              w_state_nxt = S_DOWN;
              w_incr_nxt  = w_dn_val;
            end else begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_incr_nxt = w_up_val;
          end
        end else begin
          w_cnt_nxt = r_cnt + DW_WIDTH'(1);
        end
      end
      S_DOWN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_dwell_end) begin
          w_cnt_nxt = '0;
          if (r_incr == r_fstart) begin
            w_state_nxt = S_UP;
            w_incr_nxt  = w_up_val;
          end else begin
            w_incr_nxt = w_dn_val;
          end
        end else begin
          w_cnt_nxt = r_cnt + DW_WIDTH'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state so every output comes out of a register
  always_comb begin
    w_en_nxt   = (w_state_nxt == S_UP) || (w_state_nxt == S_DOWN);
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_dir_nxt  = (w_state_nxt == S_DOWN);
    w_done_nxt = (w_state_nxt == S_DONE);
    w_err_nxt  = (r_state == S_IDLE) && start && !abort && !w_cfg_ok;
  end

  // Datapath registers: captured sweep configuration, increment, dwell counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode   <= '0;
      r_fstart <= '0;
      r_fstop  <= '0;
      r_fstep  <= '0;
      r_dwell  <= '0;
      r_cnt    <= '0;
      r_incr   <= '0;
    end else begin
      if (w_accept) begin
        r_mode   <= mode;
        r_fstart <= f_start;
        r_fstop  <= f_stop;
        r_fstep  <= f_step;
        r_dwell  <= w_dwell_eff;
      end
      r_cnt  <= w_cnt_nxt;
      r_incr <= w_incr_nxt;
    end
  end

  // Registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en   <= 1'b0;
      r_busy <= 1'b0;
      r_dir  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_en   <= w_en_nxt;
      r_busy <= w_busy_nxt;
      r_dir  <= w_dir_nxt;
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign en   = r_en;
  assign incr = r_incr;
  assign busy = r_busy;
  assign dir  = r_dir;
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_sine_sweep_ctrl.sv
// Directed self-checking bench for sine_sweep_ctrl (default widths).
module tb_sine_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [1:0]  mode;
  logic [7:0]  f_start, f_stop, f_step;
  logic [15:0] dwell;
  logic        en, busy, dir, done, err;
  logic [7:0]  incr;

  int errors = 0;
  int checks = 0;

  sine_sweep_ctrl #(.D_WIDTH(8), .DW_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .en(en), .incr(incr), .busy(busy), .dir(dir), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Observed vector: {en, busy, dir, done, err, incr}
  function automatic logic [12:0] obs();
    return {en, busy, dir, done, err, incr};
  endfunction

  function automatic logic [12:0] ev(input logic e, input logic b, input logic d,
                                     input logic dn, input logic er, input logic [7:0] v);
    return {e, b, d, dn, er, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [1:0] m, input logic [7:0] fs, input logic [7:0] fe,
                       input logic [7:0] st, input logic [15:0] dw);
    mode = m; f_start = fs; f_stop = fe; f_step = st; dwell = dw;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    setup(2'b00, 8'd10, 8'd20, 8'd4, 16'd3);
    tick(); tick();
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0, 8'd0)) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", obs(), ev(0, 0, 0, 0, 0, 8'd0));
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    tick();
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0, 8'd0)) begin
      errors++; $display("FAIL reset_idle got=%h exp=%h", obs(), ev(0, 0, 0, 0, 0, 8'd0));
    end
  endtask

  task automatic test_single();
    logic [7:0] vals [4] = '{8'd10, 8'd14, 8'd18, 8'd20};
    setup(2'b00, 8'd10, 8'd20, 8'd4, 16'd3);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (obs() !== ev(1, 1, 0, 0, 0, vals[i/3])) begin
        errors++; $display("FAIL single_step%0d got=%h exp=%h", i, obs(), ev(1, 1, 0, 0, 0, vals[i/3]));
      end
      tick();
    end
    checks++;
    if (obs() !== ev(0, 1, 0, 1, 0, 8'd20)) begin
      errors++; $display("FAIL single_done got=%h exp=%h", obs(), ev(0, 1, 0, 1, 0, 8'd20));
    end
    tick();
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0, 8'd20)) begin
      errors++; $display("FAIL single_idle got=%h exp=%h", obs(), ev(0, 0, 0, 0, 0, 8'd20));
    end
  endtask

  task automatic test_reject();
    setup(2'b00, 8'd30, 8'd20, 8'd4, 16'd3);
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 1, 8'd20)) begin
      errors++; $display("FAIL reject_order got=%h exp=%h", obs(), ev(0, 0, 0, 0, 1, 8'd20));
    end
    tick();
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0, 8'd20)) begin
      errors++; $display("FAIL reject_order_clear got=%h exp=%h", obs(), ev(0, 0, 0, 0, 0, 8'd20));
    end
    setup(2'b00, 8'd10, 8'd20, 8'd0, 16'd3);
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 1, 8'd20)) begin
      errors++; $display("FAIL reject_step0 got=%h exp=%h", obs(), ev(0, 0, 0, 0, 1, 8'd20));
    end
    tick();
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0, 8'd20)) begin
      errors++; $display("FAIL reject_step0_clear got=%h exp=%h", obs(), ev(0, 0, 0, 0, 0, 8'd20));
    end
    // abort wins over a simultaneous start, valid or not
    setup(2'b00, 8'd10, 8'd20, 8'd4, 16'd3);
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0, 8'd20)) begin
      errors++; $display("FAIL abort_start_idle got=%h exp=%h", obs(), ev(0, 0, 0, 0, 0, 8'd20));
    end
    setup(2'b00, 8'd30, 8'd20, 8'd4, 16'd3);
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0, 8'd20)) begin
      errors++; $display("FAIL abort_start_noerr got=%h exp=%h", obs(), ev(0, 0, 0, 0, 0, 8'd20));
    end
  endtask

  task automatic test_abort();
    setup(2'b00, 8'd10, 8'd20, 8'd4, 16'd3);
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    checks++;
    if (obs() !== ev(1, 1, 0, 0, 0, 8'd14)) begin
      errors++; $display("FAIL abort_pre got=%h exp=%h", obs(), ev(1, 1, 0, 0, 0, 8'd14));
    end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0, 8'd14)) begin
      errors++; $display("FAIL abort_idle got=%h exp=%h", obs(), ev(0, 0, 0, 0, 0, 8'd14));
    end
    tick();
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0, 8'd14)) begin
      errors++; $display("FAIL abort_nodone got=%h exp=%h", obs(), ev(0, 0, 0, 0, 0, 8'd14));
    end
  endtask

  task automatic test_rst_mid();
    setup(2'b00, 8'd10, 8'd20, 8'd4, 16'd3);
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0, 8'd0)) begin
      errors++; $display("FAIL rst_mid got=%h exp=%h", obs(), ev(0, 0, 0, 0, 0, 8'd0));
    end
    tick();
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0, 8'd0)) begin
      errors++; $display("FAIL rst_mid_nodone got=%h exp=%h", obs(), ev(0, 0, 0, 0, 0, 8'd0));
    end
  endtask

  task automatic test_bounce();
    logic [7:0] vals [7] = '{8'd10, 8'd14, 8'd18, 8'd20, 8'd16, 8'd12, 8'd10};
    logic       dirs [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    setup(2'b10, 8'd10, 8'd20, 8'd4, 16'd3);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (obs() !== ev(1, 1, dirs[i/3], 0, 0, vals[i/3])) begin
        errors++; $display("FAIL bounce_step%0d got=%h exp=%h", i, obs(), ev(1, 1, dirs[i/3], 0, 0, vals[i/3]));
      end
      tick();
    end
    // third cycle of the down-leg dwell at 10, then wrap back up to 14
    checks++;
    if (obs() !== ev(1, 1, 1, 0, 0, 8'd10)) begin
      errors++; $display("FAIL bounce_last_down got=%h exp=%h", obs(), ev(1, 1, 1, 0, 0, 8'd10));
    end
    tick();
    checks++;
    if (obs() !== ev(1, 1, 0, 0, 0, 8'd14)) begin
      errors++; $display("FAIL bounce_turn_up got=%h exp=%h", obs(), ev(1, 1, 0, 0, 0, 8'd14));
    end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0, 8'd14)) begin
      errors++; $display("FAIL bounce_abort got=%h exp=%h", obs(), ev(0, 0, 0, 0, 0, 8'd14));
    end
  endtask

  task automatic test_loop_overflow();
    logic [7:0] vals [7] = '{8'd250, 8'd254, 8'd255, 8'd250, 8'd254, 8'd255, 8'd250};
    setup(2'b01, 8'd250, 8'd255, 8'd4, 16'd0);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (obs() !== ev(1, 1, 0, 0, 0, vals[i])) begin
        errors++; $display("FAIL loop_step%0d got=%h exp=%h", i, obs(), ev(1, 1, 0, 0, 0, vals[i]));
      end
      tick();
    end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0, 8'd254)) begin
      errors++; $display("FAIL loop_abort got=%h exp=%h", obs(), ev(0, 0, 0, 0, 0, 8'd254));
    end
  endtask

  task automatic test_equal_bounds();
    logic d;
    setup(2'b10, 8'd50, 8'd50, 8'd5, 16'd2);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d = ((i / 2) % 2) == 1;
      checks++;
      if (obs() !== ev(1, 1, d, 0, 0, 8'd50)) begin
        errors++; $display("FAIL equal_bounce%0d got=%h exp=%h", i, obs(), ev(1, 1, d, 0, 0, 8'd50));
      end
      tick();
    end
    abort = 1'b1; tick(); abort = 1'b0;
    // mode 11 behaves as single sweep
    setup(2'b11, 8'd50, 8'd50, 8'd5, 16'd1);
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (obs() !== ev(1, 1, 0, 0, 0, 8'd50)) begin
      errors++; $display("FAIL mode3_up got=%h exp=%h", obs(), ev(1, 1, 0, 0, 0, 8'd50));
    end
    tick();
    checks++;
    if (obs() !== ev(0, 1, 0, 1, 0, 8'd50)) begin
      errors++; $display("FAIL mode3_done got=%h exp=%h", obs(), ev(0, 1, 0, 1, 0, 8'd50));
    end
    tick();
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0, 8'd50)) begin
      errors++; $display("FAIL mode3_idle got=%h exp=%h", obs(), ev(0, 0, 0, 0, 0, 8'd50));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [4] = '{8'd10, 8'd14, 8'd18, 8'd20};
    setup(2'b00, 8'd10, 8'd20, 8'd4, 16'd1);
    start = 1'b1; tick();
    f_start = 8'd12;   // must be ignored until the next accepted start
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs() !== ev(1, 1, 0, 0, 0, vals[i])) begin
        errors++; $display("FAIL b2b_step%0d got=%h exp=%h", i, obs(), ev(1, 1, 0, 0, 0, vals[i]));
      end
      tick();
    end
    checks++;
    if (obs() !== ev(0, 1, 0, 1, 0, 8'd20)) begin
      errors++; $display("FAIL b2b_done got=%h exp=%h", obs(), ev(0, 1, 0, 1, 0, 8'd20));
    end
    tick();
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0, 8'd20)) begin
      errors++; $display("FAIL b2b_idle got=%h exp=%h", obs(), ev(0, 0, 0, 0, 0, 8'd20));
    end
    tick();
    checks++;
    if (obs() !== ev(1, 1, 0, 0, 0, 8'd12)) begin
      errors++; $display("FAIL b2b_restart got=%h exp=%h", obs(), ev(1, 1, 0, 0, 0, 8'd12));
    end
    start = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0, 8'd12)) begin
      errors++; $display("FAIL b2b_abort got=%h exp=%h", obs(), ev(0, 0, 0, 0, 0, 8'd12));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reject();
    test_abort();
    test_rst_mid();
    test_bounce();
    test_loop_overflow();
    test_equal_bounds();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
